// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared constants for the nibble-serial adder: FSM state encodings and slice width.
package nibble_serial_add_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/nibble_serial_add_ctrl_add4.sv
// 4-bit ripple-carry adder; c3 (carry into bit 3) is exposed so the caller can form overflow.
module nibble_add4
    import nibble_serial_add_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout,
    output logic                c3
);

    logic [NIBBLE_W:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[NIBBLE_W];
    assign c3   = carry[NIBBLE_W-1];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Adds two WIDTH-bit operands one nibble per cycle (LSB first) through a single 4-bit adder.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4,
    localparam int WIDTH  = NIBBLE_W * NIBBLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    logic [1:0]          state;
    logic [IDX_W-1:0]    idx;
    logic                carry;
    logic [WIDTH-1:0]    a_reg;
    logic [WIDTH-1:0]    b_reg;
    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_cout;
    logic                nib_c3;

    nibble_add4 u_add4 (
        .a    (a_reg[idx*NIBBLE_W +: NIBBLE_W]),
        .b    (b_reg[idx*NIBBLE_W +: NIBBLE_W]),
        .cin  (carry),
        .sum  (nib_sum),
        .cout (nib_cout),
        .c3   (nib_c3)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            idx   <= '0;
            carry <= 1'b0;
            a_reg <= '0;
            b_reg <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                        carry <= cin;
                        idx   <= '0;
                        sum   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum[idx*NIBBLE_W +: NIBBLE_W] <= nib_sum;
                    carry <= nib_cout;
                    // Top nibble: its carries become the block's cout and overflow.
                    if (idx == LAST_IDX) begin
                        cout  <= nib_cout;
                        ovf   <= nib_c3 ^ nib_cout;
                        idx   <= '0;
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state == ST_RUN);
    assign out_valid = (state == ST_DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl (NIBBLES=4): directed vectors and a streaming run, scoreboard-checked.
module tb_nibble_serial_add_ctrl;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;
    logic [1:0]   dbg_state;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic rand_rdy = 1'b0;

    // {cout, ovf, sum}
    logic [W+1:0] exp_q[$];

    nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expected entry per output handshake.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'(sum), 32'hFFFF_FFFF);
            end else begin
                logic [W+1:0] e;
                e = exp_q.pop_front();
                check("sum", 32'(sum), 32'(e[W-1:0]));
                check("cout", 32'(cout), 32'(e[W+1]));
                check("ovf", 32'(ovf), 32'(e[W]));
            end
        end
    end

    function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        logic [W:0] s;
        logic       o;
        s = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, cv};
        o = (av[W-1] == bv[W-1]) && (s[W-1] != av[W-1]);
        return {s[W], o, s[W-1:0]};
    endfunction

    // Entered and left at posedge+1; returns the cycle stamp of the accepting edge.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv, output int acc);
        int n;
        n = 0;
        in_valid = 1'b1;
        a = av;
        b = bv;
        cin = cv;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(n), 32'd0);
            in_valid = 1'b0;
            acc = cyc;
            return;
        end
        @(posedge clk); #1;
        acc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) check("valid_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        int acc, prev, n;
        logic [W-1:0] av, bv;
        logic cv;

        repeat (3) @(posedge clk);
        #1;
        check("rst_sum", 32'(sum), 32'h0);
        check("rst_cout", 32'(cout), 32'h0);
        check("rst_ovf", 32'(ovf), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'h1);

        // Full carry ripple, latency check
        exp_q.push_back({1'b1, 1'b0, 16'h0000});
        send(16'hFFFF, 16'h0001, 1'b0, acc);
        check("busy_after_accept", 32'(busy), 32'h1);
        check("in_ready_in_run", 32'(in_ready), 32'h0);
        wait_valid(n);
        check("latency", 32'(n), 32'd4);

        // Operands changed right after accept must not matter
        exp_q.push_back({1'b0, 1'b0, 16'h5556});
        send(16'h1234, 16'h4321, 1'b1, acc);
        a = 16'hAAAA;
        b = 16'h5555;
        cin = 1'b0;

        exp_q.push_back({1'b0, 1'b1, 16'h8000});
        send(16'h7FFF, 16'h0001, 1'b0, acc);
        exp_q.push_back({1'b1, 1'b1, 16'h0000});
        send(16'h8000, 16'h8000, 1'b0, acc);

        // Backpressure, and in_valid pulses during RUN and DONE
        wait_valid(n);
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_q.push_back({1'b0, 1'b0, 16'h3333});
        send(16'h1111, 16'h2222, 1'b0, acc);
        in_valid = 1'b1;
        a = 16'h0F0F;
        b = 16'h0101;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_valid(n);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 32'(out_valid), 32'h1);
            check("hold_sum", 32'(sum), 32'h3333);
            check("hold_cout", 32'(cout), 32'h0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_hs", 32'(in_ready), 32'h1);
        check("out_valid_after_hs", 32'(out_valid), 32'h0);

        // Reset during the second RUN cycle
        send(16'hFFFF, 16'hFFFF, 1'b0, acc);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("abort_sum", 32'(sum), 32'h0);
        check("abort_out_valid", 32'(out_valid), 32'h0);
        check("abort_in_ready", 32'(in_ready), 32'h1);
        check("abort_busy", 32'(busy), 32'h0);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        exp_q.push_back({1'b0, 1'b0, 16'h0010});
        send(16'h0008, 16'h0008, 1'b0, acc);

        // Streaming with random out_ready
        rand_rdy = 1'b1;
        prev = 0;
        for (int i = 0; i < 20; i++) begin
            av = 16'($urandom_range(0, 65535));
            bv = 16'($urandom_range(0, 65535));
            cv = 1'($urandom_range(0, 1));
            exp_q.push_back(model(av, bv, cv));
            send(av, bv, cv, acc);
            if (i > 0) check("accept_spacing_ge6", 32'(acc - prev >= 6), 32'h1);
            prev = acc;
        end
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || !in_ready) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
- Sequencer that adds two WIDTH-bit operands by reusing a single 4-bit ripple adder once per cycle, least-significant nibble first, with the carry held in a register between nibbles.
- Sits between a valid/ready producer and consumer in the arithmetic datapath.
- Trades latency (NIBBLES cycles per add) for the area of one 4-bit adder.

Parameters:
- NIBBLES, 4, number of 4-bit slices per operand (legal range 2 to 16).
- WIDTH, 4*NIBBLES, operand and result width (derived, not overridden).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand set presented.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry into nibble 0.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- sum  output  WIDTH  A+B+cin, modulo 2^WIDTH.
- cout  output  1  carry out of the top nibble.
- ovf  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB).
- busy  output  1  high in RUN state.

Behaviour:
- Architecture requirement: one 4-bit adder instance only. No WIDTH-bit "+" anywhere in the block.
- Reset (asynchronous, active-high) forces state IDLE, nibble index 0, carry register 0, sum 0, cout 0, ovf 0, out_valid 0, busy 0. in_ready=1 after reset deasserts.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready at an edge: latch a, b into operand registers; carry register<=cin; idx<=0; clear the sum register; go to RUN.
  - RUN: busy=1, in_ready=0. Each edge:
    - sum[4*idx+3:4*idx] <= nibble_sum(a_nib[idx], b_nib[idx], carry);
    - carry <= nibble cout;
    - idx <= idx+1.
    - On the edge where idx==NIBBLES-1, also capture cout and ovf, then go to DONE.
  - DONE: out_valid=1; sum, cout and ovf are stable. On out_valid&out_ready at an edge, go to IDLE and drop out_valid.
- Latency: out_valid rises exactly NIBBLES cycles after the accepting edge.
- Throughput: one result per NIBBLES+2 cycles. The accept and the output handshake never occur in the same cycle (in_ready is low in DONE).
- in_valid while RUN or DONE: ignored; no operand register changes.
- a, b and cin may change freely after the accept; only the latched copies are used.
- out_ready low in DONE: hold indefinitely; outputs do not change.
- Outputs are registered; in_ready, busy and out_valid decode directly from the state register.
- ovf is computed from the top nibble's bit-3 carry-in and carry-out.
- The idx counter width is clog2(NIBBLES). idx does not wrap beyond NIBBLES-1 during RUN.
- Reset asserted mid-RUN or in DONE: immediate return to the reset state; the partial result is discarded with no out_valid pulse.
- Illegal state encoding recovers to IDLE.

Decomposition:
- Shared package holds:
  - state enum constants ST_IDLE, ST_RUN, ST_DONE (2-bit);
  - NIBBLE_W=4.
- One sub-module, nibble_add4: a 4-bit ripple adder with inputs a[3:0], b[3:0], cin and outputs sum[3:0], cout, c3 (carry into bit 3, used for ovf). Internal carries must chain bit to bit.
- The controller, registers and index counter stay in nibble_serial_add_ctrl.

Test Plan:
- 0xFFFF+0x0001, cin=0 -> out_valid exactly 4 cycles after accept; sum=0x0000, cout=1, ovf=0.
- 0x1234+0x4321, cin=1 -> sum=0x5556, cout=0, ovf=0. Inputs are changed to 0xAAAA/0x5555 the cycle after accept; the result is unaffected.
- 0x7FFF+0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Also 0x8000+0x8000 -> sum=0x0000, cout=1, ovf=1.
- Backpressure: out_ready held low 5 cycles after out_valid -> sum/cout/out_valid stable. in_valid pulsed with 0x0F0F+0x0101 during RUN and DONE -> ignored. in_ready returns 1 one cycle after the handshake.
- Reset pulse in the 2nd RUN cycle of 0xFFFF+0xFFFF -> sum=0, out_valid=0, in_ready=1 immediately. A new add of 0x0008+0x0008 -> 0x0010, no carry leaking from the aborted operation.
- Back-to-back streaming of 20 random operand pairs with random out_ready -> every result matches the reference model (a+b+cin), and each completes in NIBBLES+2 cycles minimum.
